// File: rtl/df_dbg_pkg.sv
// Shared types for the dataflow deadlock monitor: FSM states, edge report record, lowest-set-bit helper.
package df_dbg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILTER = 3'd1,
      ST_SELECT = 3'd2,
      ST_WALK   = 3'd3,
      ST_FINISH = 3'd4
   } dl_state_e;

   // Fields are sized for the largest supported region (32 processes).
   localparam int RPT_IDX_W = 5;

   typedef struct packed {
      logic [RPT_IDX_W-1:0] src;
      logic [RPT_IDX_W-1:0] dst;
      logic [RPT_IDX_W-1:0] cycle_id;
      logic                 last;
   } rpt_t;

   function automatic logic [RPT_IDX_W-1:0] lowest_set(input logic [31:0] v);
      lowest_set = '0;
      for (int i = 31; i >= 0; i--)
         if (v[i]) lowest_set = RPT_IDX_W'(i);
   endfunction

endpackage

// File: rtl/df_prio_enc.sv
// Lowest-index priority encoder: one-hot grant, binary index and any-set flag.
module df_prio_enc
   import df_dbg_pkg::*;
#(
   parameter int W  = 8,
   parameter int IW = $clog2(W)
) (
   input  logic [W-1:0]  req,
   output logic [W-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [31:0] req32;

   assign req32  = 32'(req);
   assign onehot = req & (~req + W'(1));
   assign idx    = IW'(lowest_set(req32));
   assign any    = |req;

endmodule

// File: rtl/df_deadlock_monitor.sv
// Dataflow deadlock monitor: filters persistent stalls, then walks and reports each dependence cycle.
// Optional DL_TIMESTAMP_EN adds a free-running timestamp and the dl_detect_time port.
module df_deadlock_monitor
   import df_dbg_pkg::*;
#(
   parameter int PROC_NUM    = 8,
   parameter int IDX_W       = $clog2(PROC_NUM),
   parameter int CNT_W       = 32,
   parameter int KEEP_THRESH = 1000,
   parameter int MAX_CYCLES  = 4
) (
   input  logic                       dl_clock,
   input  logic                       dl_reset,
   input  logic                       dl_enable,
   input  logic [PROC_NUM*PROC_NUM-1:0] dl_blk_mat,
   output logic                       dl_detect_out,
   output logic                       rpt_valid,
   input  logic                       rpt_ready,
   output logic [IDX_W-1:0]           rpt_src,
   output logic [IDX_W-1:0]           rpt_dst,
   output logic [IDX_W-1:0]           rpt_cycle_id,
   output logic                       rpt_last,
   output logic                       token_clear,
   output logic [IDX_W-1:0]           dl_cycles,
`ifdef DL_TIMESTAMP_EN
   output logic [47:0]                dl_detect_time,
`endif
   output logic                       dl_finished
);

   localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(KEEP_THRESH - 1);
   localparam logic [IDX_W-1:0] MAX_CYC   = IDX_W'(MAX_CYCLES);

   logic [PROC_NUM-1:0][PROC_NUM-1:0] mat;
   logic [PROC_NUM-1:0] blk_vec;

   dl_state_e           state;
   logic [PROC_NUM-1:0] detect_reg, done_reg, visited;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    cur, origin, cyc_cnt;
   logic                hold_vld;
   logic [IDX_W-1:0]    hold_dst;
   logic                tok_r, fin_r;

   logic [PROC_NUM-1:0] org_oh, nxt_oh, dst_oh;
   logic [IDX_W-1:0]    org_idx, nxt_idx, edge_dst;
   logic                org_any, nxt_any;
   logic                walk_vld, hs, closes, at_origin, stall_gone, filt_done;
   rpt_t                rpt;

   assign mat = dl_blk_mat;

   for (genvar i = 0; i < PROC_NUM; i++) begin : g_row
      assign blk_vec[i] = |mat[i];
   end

   df_prio_enc #(.W(PROC_NUM), .IW(IDX_W)) u_org (
      .req    (detect_reg & ~done_reg),
      .onehot (org_oh),
      .idx    (org_idx),
      .any    (org_any)
   );

   df_prio_enc #(.W(PROC_NUM), .IW(IDX_W)) u_nxt (
      .req    (mat[cur]),
      .onehot (nxt_oh),
      .idx    (nxt_idx),
      .any    (nxt_any)
   );

   // A stalled edge is frozen in hold_* so a changing matrix cannot disturb the offered report.
   assign edge_dst   = hold_vld ? hold_dst : nxt_idx;
   assign dst_oh     = hold_vld ? (PROC_NUM'(1) << hold_dst) : nxt_oh;
   assign walk_vld   = (state == ST_WALK) && dl_enable && (hold_vld || nxt_any);
   assign hs         = walk_vld && rpt_ready;
   assign closes     = |(visited & dst_oh);
   assign at_origin  = (edge_dst == origin);
   assign stall_gone = |(detect_reg & ~blk_vec);
   assign filt_done  = (state == ST_FILTER) && dl_enable && !stall_gone && (cnt >= THRESH_M1);

   always_comb begin
      rpt          = '0;
      if (walk_vld) begin
         rpt.src      = RPT_IDX_W'(cur);
         rpt.dst      = RPT_IDX_W'(edge_dst);
         rpt.cycle_id = RPT_IDX_W'(cyc_cnt + IDX_W'(1));
         rpt.last     = closes;
      end
   end

   assign rpt_valid     = walk_vld;
   assign rpt_src       = IDX_W'(rpt.src);
   assign rpt_dst       = IDX_W'(rpt.dst);
   assign rpt_cycle_id  = IDX_W'(rpt.cycle_id);
   assign rpt_last      = rpt.last;
   assign token_clear   = tok_r;
   assign dl_cycles     = cyc_cnt;
   assign dl_finished   = fin_r;
   assign dl_detect_out = (state == ST_SELECT) || (state == ST_WALK) || (state == ST_FINISH);

   always_ff @(posedge dl_clock or posedge dl_reset) begin
      if (dl_reset) begin
         hold_vld <= 1'b0;
         hold_dst <= '0;
      end else if (walk_vld && !rpt_ready) begin
         hold_vld <= 1'b1;
         if (!hold_vld) hold_dst <= nxt_idx;
      end else begin
         hold_vld <= 1'b0;
      end
   end

   always_ff @(posedge dl_clock or posedge dl_reset) begin
      if (dl_reset) begin
         state      <= ST_IDLE;
         detect_reg <= '0;
         done_reg   <= '0;
         visited    <= '0;
         cnt        <= '0;
         cur        <= '0;
         origin     <= '0;
         cyc_cnt    <= '0;
         tok_r      <= 1'b0;
         fin_r      <= 1'b0;
      end else begin
         tok_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               detect_reg <= blk_vec;
               cnt        <= '0;
               done_reg   <= '0;
               cyc_cnt    <= '0;
               if (dl_enable && (blk_vec != '0)) state <= ST_FILTER;
            end
            ST_FILTER: begin
               if (!dl_enable || stall_gone) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  if (cnt != '1) cnt <= cnt + CNT_W'(1);
                  if (filt_done) state <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (!dl_enable) begin
                  state <= ST_IDLE;
               end else if (!org_any || (cyc_cnt == MAX_CYC)) begin
                  state <= ST_FINISH;
                  fin_r <= 1'b1;
               end else begin
                  cur     <= org_idx;
                  origin  <= org_idx;
                  visited <= org_oh;
                  state   <= ST_WALK;
               end
            end
            ST_WALK: begin
               if (!dl_enable) begin
                  state <= ST_IDLE;
               end else if (hs) begin
                  // Closing on any visited node ends the cycle; only a return to origin frees the token.
                  if (closes) begin
                     tok_r    <= at_origin;
                     done_reg <= done_reg | visited;
                     cyc_cnt  <= cyc_cnt + IDX_W'(1);
                     state    <= ST_SELECT;
                  end else begin
                     visited <= visited | dst_oh;
                     cur     <= edge_dst;
                  end
               end else if (!hold_vld && !nxt_any) begin
                  state <= ST_IDLE;
               end
            end
            ST_FINISH: begin
               if (!dl_enable || (blk_vec == '0)) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef DL_TIMESTAMP_EN
   logic [47:0] ts_cnt;

   always_ff @(posedge dl_clock or posedge dl_reset) begin
      if (dl_reset) begin
         ts_cnt         <= '0;
         dl_detect_time <= '0;
      end else begin
         ts_cnt <= ts_cnt + 48'd1;
         if (filt_done) dl_detect_time <= ts_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_df_deadlock_monitor.sv
// Directed bench for df_deadlock_monitor: table of deadlock patterns plus hand-written corner sequences.
module tb_df_deadlock_monitor;

   localparam int P   = 8;
   localparam int LAT = 1001;  // one IDLE cycle to register blk_vec, then KEEP_THRESH filter cycles

   logic           dl_clock = 1'b0;
   logic           dl_reset, dl_enable, rpt_ready;
   logic [P*P-1:0] dl_blk_mat;
   logic           dl_detect_out, rpt_valid, rpt_last, token_clear, dl_finished;
   logic [2:0]     rpt_src, rpt_dst, rpt_cycle_id, dl_cycles;
`ifdef DL_TIMESTAMP_EN
   logic [47:0]    dl_detect_time;
`endif

   int total = 0;
   int bad   = 0;

   always #5 dl_clock = ~dl_clock;

   df_deadlock_monitor dut (
      .dl_clock      (dl_clock),
      .dl_reset      (dl_reset),
      .dl_enable     (dl_enable),
      .dl_blk_mat    (dl_blk_mat),
      .dl_detect_out (dl_detect_out),
      .rpt_valid     (rpt_valid),
      .rpt_ready     (rpt_ready),
      .rpt_src       (rpt_src),
      .rpt_dst       (rpt_dst),
      .rpt_cycle_id  (rpt_cycle_id),
      .rpt_last      (rpt_last),
      .token_clear   (token_clear),
      .dl_cycles     (dl_cycles),
`ifdef DL_TIMESTAMP_EN
      .dl_detect_time(dl_detect_time),
`endif
      .dl_finished   (dl_finished)
   );

   typedef struct {
      logic [P-1:0][P-1:0] m;
      int                  n_edges;
      logic [7:0][9:0]     edges;   // {src, dst, cycle_id, last}
      int                  cycles;
      int                  toks;
   } vec_t;

   vec_t vt [5];

   function automatic logic [9:0] e(input int s, input int d, input int id, input int l);
      return {3'(s), 3'(d), 3'(id), 1'(l)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge dl_clock);
      #1;
   endtask

   task automatic do_reset();
      dl_reset   = 1'b1;
      dl_enable  = 1'b1;
      rpt_ready  = 1'b0;
      dl_blk_mat = '0;
      step();
      dl_reset = 1'b0;
   endtask

   task automatic wait_detect(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!dl_detect_out && n < 3000);
   endtask

   // Collect accepted-by-ready edges until dl_finished; returns edge list and token pulse count.
   task automatic collect(output logic [9:0] got [$], output int nt);
      got = {};
      nt  = 0;
      for (int c = 0; c < 200 && !dl_finished; c++) begin
         if (rpt_valid && rpt_ready) got.push_back({rpt_src, rpt_dst, rpt_cycle_id, rpt_last});
         if (token_clear) nt++;
         step();
      end
   endtask

   task automatic run_vec(input int k);
      int          n, nt;
      logic [9:0]  got [$];
      do_reset();
      dl_blk_mat = vt[k].m;
      rpt_ready  = 1'b1;
      wait_detect(n);
      chk($sformatf("v%0d latency", k), 64'(n), 64'(LAT));
      collect(got, nt);
      chk($sformatf("v%0d finished", k), 64'(dl_finished), 64'd1);
      chk($sformatf("v%0d detect_held", k), 64'(dl_detect_out), 64'd1);
      chk($sformatf("v%0d dl_cycles", k), 64'(dl_cycles), 64'(vt[k].cycles));
      chk($sformatf("v%0d token_pulses", k), 64'(nt), 64'(vt[k].toks));
      chk($sformatf("v%0d edge_count", k), 64'(got.size()), 64'(vt[k].n_edges));
      for (int i = 0; i < vt[k].n_edges && i < got.size(); i++)
         chk($sformatf("v%0d edge%0d", k, i), 64'(got[i]), 64'(vt[k].edges[i]));
      dl_blk_mat = '0;
      repeat (3) step();
      chk($sformatf("v%0d idle_detect", k), 64'(dl_detect_out), 64'd0);
      chk($sformatf("v%0d finished_sticky", k), 64'(dl_finished), 64'd1);
      chk($sformatf("v%0d cycles_cleared", k), 64'(dl_cycles), 64'd0);
   endtask

   initial begin
      int          n, nt, rose;
      logic [9:0]  got [$];
      logic [P-1:0][P-1:0] m;

      for (int k = 0; k < 5; k++) begin
         vt[k].m     = '0;
         vt[k].edges = '0;
      end
      // two-process deadlock
      vt[0].m[0][1] = 1'b1; vt[0].m[1][0] = 1'b1;
      vt[0].n_edges = 2; vt[0].cycles = 1; vt[0].toks = 1;
      vt[0].edges[0] = e(0, 1, 1, 0); vt[0].edges[1] = e(1, 0, 1, 1);
      // two disjoint cycles
      vt[1].m[0][2] = 1'b1; vt[1].m[2][0] = 1'b1;
      vt[1].m[3][5] = 1'b1; vt[1].m[5][4] = 1'b1; vt[1].m[4][3] = 1'b1;
      vt[1].n_edges = 5; vt[1].cycles = 2; vt[1].toks = 2;
      vt[1].edges[0] = e(0, 2, 1, 0); vt[1].edges[1] = e(2, 0, 1, 1);
      vt[1].edges[2] = e(3, 5, 2, 0); vt[1].edges[3] = e(5, 4, 2, 0);
      vt[1].edges[4] = e(4, 3, 2, 1);
      // ring not through origin
      vt[2].m[1][2] = 1'b1; vt[2].m[2][3] = 1'b1; vt[2].m[3][2] = 1'b1;
      vt[2].n_edges = 3; vt[2].cycles = 1; vt[2].toks = 0;
      vt[2].edges[0] = e(1, 2, 1, 0); vt[2].edges[1] = e(2, 3, 1, 0);
      vt[2].edges[2] = e(3, 2, 1, 1);
      // lowest-index successor chosen when a row has several waits
      vt[3].m[0][1] = 1'b1; vt[3].m[0][3] = 1'b1; vt[3].m[1][2] = 1'b1; vt[3].m[2][0] = 1'b1;
      vt[3].n_edges = 3; vt[3].cycles = 1; vt[3].toks = 1;
      vt[3].edges[0] = e(0, 1, 1, 0); vt[3].edges[1] = e(1, 2, 1, 0);
      vt[3].edges[2] = e(2, 0, 1, 1);
      // eight self-loops, capped at MAX_CYCLES = 4
      for (int i = 0; i < P; i++) vt[4].m[i][i] = 1'b1;
      vt[4].n_edges = 4; vt[4].cycles = 4; vt[4].toks = 4;
      for (int i = 0; i < 4; i++) vt[4].edges[i] = e(i, i, i + 1, 1);

      // reset state
      dl_reset = 1'b1; dl_enable = 1'b1; rpt_ready = 1'b0; dl_blk_mat = '0;
      #12;
      chk("reset_outputs",
          64'({dl_detect_out, rpt_valid, rpt_src, rpt_dst, rpt_cycle_id, rpt_last,
               token_clear, dl_cycles, dl_finished}), 64'd0);
      step();
      dl_reset = 1'b0;

      // transient stall shorter than the threshold
      m = '0; m[0][1] = 1'b1;
      dl_blk_mat = m;
      rose = 0;
      repeat (500) begin step(); if (dl_detect_out) rose = 1; end
      dl_blk_mat = '0;
      repeat (5) begin step(); if (dl_detect_out) rose = 1; end
      chk("transient_no_detect", 64'(rose), 64'd0);
      dl_blk_mat = vt[0].m;
      wait_detect(n);
      chk("transient_fresh_latency", 64'(n), 64'(LAT));

      for (int k = 0; k < 5; k++) run_vec(k);

      // back-pressure on the first edge, matrix perturbed while stalled
      do_reset();
      dl_blk_mat = vt[0].m;
      wait_detect(n);
      step();
      for (int c = 0; c < 7; c++) begin
         chk($sformatf("bp_hold%0d", c), 64'({rpt_valid, rpt_src, rpt_dst}), 64'({1'b1, 3'd0, 3'd1}));
         if (c == 2) begin m = vt[0].m; m[0][0] = 1'b1; dl_blk_mat = m; end
         if (c == 5) dl_blk_mat = vt[0].m;
         step();
      end
      rpt_ready = 1'b1;
      collect(got, nt);
      chk("bp_edge_count", 64'(got.size()), 64'd2);
      if (got.size() == 2) begin
         chk("bp_edge0", 64'(got[0]), 64'(e(0, 1, 1, 0)));
         chk("bp_edge1", 64'(got[1]), 64'(e(1, 0, 1, 1)));
      end
      chk("bp_tokens", 64'(nt), 64'd1);

      // asynchronous reset in the middle of a walk
      do_reset();
      dl_blk_mat = vt[1].m;
      wait_detect(n);
      step();
      chk("mid_walk_valid", 64'(rpt_valid), 64'd1);
      #2 dl_reset = 1'b1;
      #1;
      chk("async_reset_outputs",
          64'({dl_detect_out, rpt_valid, rpt_src, rpt_dst, rpt_cycle_id, rpt_last,
               token_clear, dl_cycles, dl_finished}), 64'd0);
      step();
      dl_reset  = 1'b0;
      rpt_ready = 1'b1;
      wait_detect(n);
      chk("post_reset_latency", 64'(n), 64'(LAT));

      // enable dropped while an edge is offered
      rpt_ready = 1'b0;
      step();
      chk("en_valid_before", 64'(rpt_valid), 64'd1);
      dl_enable = 1'b0;
      #1;
      chk("en_valid_dropped", 64'(rpt_valid), 64'd0);
      step();
      chk("en_detect_cleared", 64'(dl_detect_out), 64'd0);
      dl_enable = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/df_deadlock_monitor.md
Name: df_deadlock_monitor

Overview:
- Synthesisable, parametrised successor to the simulation-only deadlock reporter for dataflow regions.
- Watches a PROC_NUM x PROC_NUM blocked-on matrix from the dataflow processes and filters transient stalls with a programmable persistence threshold.
- On a persistent stall it walks each dependence cycle and streams one edge per handshake to a debug sink (trace FIFO / AXI-Lite regs).
- Instantiated once per dataflow region, beside the region's output-sync logic.

Parameters:
- PROC_NUM, 8, number of dataflow processes (2..32).
- IDX_W, $clog2(PROC_NUM), process index width.
- CNT_W, 32, persistence counter width.
- KEEP_THRESH, 1000, cycles a stall must persist before it counts as a deadlock.
- MAX_CYCLES, 4, maximum dependence cycles reported per detection.

Ports:
- dl_clock  in  1  clock.
- dl_reset  in  1  reset.
- dl_enable  in  1  monitor enable; when low the FSM is held in IDLE.
- dl_blk_mat  in  PROC_NUM*PROC_NUM  bit [i*PROC_NUM+j]: process i is blocked waiting on process j.
- dl_detect_out  out  1  high from deadlock confirmation until return to IDLE.
- rpt_valid  out  1  edge report valid.
- rpt_ready  in  1  sink accepts the edge report.
- rpt_src  out  IDX_W  blocked process index.
- rpt_dst  out  IDX_W  process it waits on.
- rpt_cycle_id  out  IDX_W  1-based cycle number.
- rpt_last  out  1  last edge of the current cycle.
- token_clear  out  1  one-cycle pulse when a cycle closes on its origin.
- dl_cycles  out  IDX_W  number of cycles reported.
- dl_finished  out  1  sticky; reporting complete.

Interface (decided): single clock dl_clock; dl_reset is asynchronous, active-high. All flops clear on posedge dl_reset.

Behaviour:
- blk_vec[i] = OR of row i of dl_blk_mat.
- Reset: all outputs 0, FSM in IDLE.
- IDLE: detect_reg <= blk_vec and cnt <= 0 every cycle. Go to FILTER if dl_enable and blk_vec != 0.
- FILTER:
  - If (detect_reg & ~blk_vec) != 0, go to IDLE and clear cnt.
  - Else cnt increments, saturating at all-ones.
  - When cnt >= KEEP_THRESH-1, go to SELECT. Confirmation latency is exactly KEEP_THRESH cycles after entry to FILTER.
  - dl_detect_out rises on entry to SELECT.
- SELECT:
  - origin = lowest-index i with detect_reg[i] & ~done_reg[i]. Set cur <= origin; visited <= onehot(origin); go to WALK.
  - If none remain, or dl_cycles == MAX_CYCLES, go to FINISH.
- WALK:
  - nxt = lowest-index j with mat[cur][j]. Drive rpt_valid=1, rpt_src=cur, rpt_dst=nxt.
  - Outputs hold stable while rpt_valid && !rpt_ready.
  - On handshake:
    - nxt == origin: rpt_last=1, token_clear pulse, done_reg |= visited, dl_cycles++, go to SELECT.
    - nxt already visited (ring not through origin): rpt_last=1, done_reg |= visited, no token_clear, dl_cycles++, go to SELECT.
    - Otherwise: visited |= onehot(nxt), cur <= nxt, stay in WALK.
  - If row cur is all zero (stall dissolved mid-walk), drop rpt_valid and go to IDLE. Partial reports are discarded by the sink when no rpt_last is seen.
- FINISH:
  - dl_finished=1 and dl_detect_out held.
  - Leave to IDLE only when blk_vec == 0 or dl_enable == 0. This clears done_reg and dl_cycles; dl_finished stays sticky until reset.
- dl_enable low in any state: go to IDLE next cycle and drop rpt_valid (a deliberate exception to valid stability).
- Simultaneous case, rpt_ready and stall dissolution in the same cycle: the handshake completes first, and the dissolution is seen in the next WALK cycle.
- Walk length is bounded by PROC_NUM edges (guaranteed by visited).

Optional Feature:
- Macro: DL_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 48-bit counter ts_cnt and output port dl_detect_time [47:0].
  - dl_detect_time latches ts_cnt on the SELECT entry for the first cycle of a detection, and is 0 after reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package df_dbg_pkg: FSM state enum (IDLE, FILTER, SELECT, WALK, FINISH), report struct {src, dst, cycle_id, last}, and a lowest-set-bit function.
- Sub-module df_prio_enc: parametrised lowest-index one-hot/binary encoder, used for both origin and nxt selection.

Test Plan:
- Transient stall: blk_mat[0][1]=1 for 500 cycles then cleared, KEEP_THRESH=1000 -> dl_detect_out never rises and the FSM returns to IDLE.
- Two-process deadlock: blk_mat[0][1]=blk_mat[1][0]=1 held, rpt_ready=1 -> dl_detect_out after 1000 cycles; reports (0,1,id1,last0) then (1,0,id1,last1); token_clear one pulse; dl_cycles=1; dl_finished=1.
- Two disjoint cycles: 0->2->0 and 3->5->4->3, PROC_NUM=8 -> cycle 1 has edges 0-2, 2-0; cycle 2 has edges 3-5, 5-4, 4-3; dl_cycles=2.
- Back-pressure: rpt_ready low for 7 cycles on the first edge -> rpt_valid, rpt_src and rpt_dst stable throughout; no edge dropped or duplicated.
- Ring not through origin: 1->2, 2->3, 3->2 -> edges 1-2, 2-3, 3-2 with last on 3-2; no token_clear.
- Reset mid-WALK: assert dl_reset while rpt_valid=1 -> all outputs 0 asynchronously; after release, a fresh KEEP_THRESH filter period is required before dl_detect_out rises.
